// File: rtl/load_read_unit.sv
// Multi-cycle load reader (MDR role): one aligned word read over req/ready,
// then byte/half/word lane extraction with zero/sign extension into a held register.
module load_read_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [8:0] TO_LIM  = 9'(TIMEOUT);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
  } ld_req_t;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  ld_req_t     req_q, req_in;
  logic [7:0]  cnt, cnt_nxt;
  logic [8:0]  cnt_inc;
  logic        err_q, err_nxt;
  logic        cap_en, load_en, bad_align;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_val;

  assign req_in  = '{addr: addr, size: size, sign_ext: sign_ext};
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  // Illegal size or a field that would straddle the word boundary.
  assign bad_align = (size == 2'b11) ||
                     (size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    cap_en    = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          cnt_nxt = '0;
          err_nxt = bad_align;
          state_nxt = bad_align ? DONE : REQ;
        end
      end
      REQ: begin
        // Ready wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          load_en   = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_inc[7:0];
          if (cnt_inc >= TO_LIM) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_q.size)
      SZ_BYTE: ext_val = {{24{req_q.sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_val = {{16{req_q.sign_ext & half_sel[15]}}, half_sel};
      default: ext_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (cap_en)  req_q    <= req_in;
      if (load_en) data_out <= ext_val;
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = done & err_q;
  assign mem_req  = (state == REQ);
  assign mem_addr = {req_q.addr[31:2], 2'b00};

endmodule

// File: tb/tb_load_read_unit.sv
// Self-checking bench for load_read_unit; the bench plays data memory and
// tracks the expected MDR value with an arithmetic extraction model.
module tb_load_read_unit;
  logic        clk, rst, start, sign_ext, busy, done, err, mem_req, mem_ready;
  logic [1:0]  size;
  logic [31:0] addr, data_out, mem_addr, mem_rdata;
  int          checks, errors;
  logic [31:0] model_dout;

  load_read_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .size(size),
    .sign_ext(sign_ext), .busy(busy), .done(done), .err(err),
    .data_out(data_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sx);
    longint w, sh, v;
    w  = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
    sh = (sz == 0) ? 8 * (a % 4) : (sz == 1) ? 16 * ((a / 2) % 2) : 0;
    v  = rd;
    v  = (v >> sh) & ((64'sd1 << w) - 1);
    if (sx && w < 32 && v >= (64'sd1 << (w - 1))) v = v - (64'sd1 << w);
    return v[31:0];
  endfunction

  function automatic bit ref_legal(input logic [31:0] a, input logic [1:0] sz);
    return !(sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
  endfunction

  // Drives one load and reports what was observed; callers judge the results.
  // ready_at: REQ cycle (1-based) on which mem_ready is raised, 0 = never.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                          input logic [31:0] rd, input int ready_at, input bit poke_start,
                          output int reqc, output int donec, output int pulses,
                          output logic e, output logic [31:0] dout, output bit addr_bad,
                          output bit idle_after);
    reqc = 0; donec = 0; pulses = 0; e = 1'b0; dout = '0; addr_bad = 0; idle_after = 0;
    addr = a; size = sz; sign_ext = sx; start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (mem_req) begin
        reqc++;
        if (mem_addr !== {a[31:2], 2'b00}) addr_bad = 1;
        mem_ready = (reqc == ready_at);
        mem_rdata = mem_ready ? rd : $urandom;
        if (poke_start) start = 1'($urandom % 2);
      end else begin
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
        start = 1'b0;
      end
      if (done) begin
        pulses++; donec = c; e = err; dout = data_out;
        mem_ready = 1'b0; start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    if (done) pulses++;
    idle_after = !busy && !mem_req;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; addr = 32'h0000_1004; size = 2'b10; sign_ext = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, err, mem_req} !== 4'b0) begin
        errors++; $display("FAIL reset_ctrl cyc%0d: busy/done/err/req=%b want 0000", i, {busy, done, err, mem_req});
      end
      checks++;
      if (mem_addr !== 32'h0 || data_out !== 32'h0) begin
        errors++; $display("FAIL reset_data: mem_addr=%h data_out=%h want 0/0", mem_addr, data_out);
      end
    end
    start = 1'b0; mem_ready = 1'b0; rst = 1'b0; model_dout = '0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b mem_req=%b want 0/0", busy, mem_req);
    end
  endtask

  task automatic test_word_load;
    int rq, dc, pl; logic e; logic [31:0] d; bit ab, ia;
    run_load(32'h0000_1004, 2'b10, 1'b0, 32'hDEAD_BEEF, 1, 0, rq, dc, pl, e, d, ab, ia);
    model_dout = 32'hDEAD_BEEF;
    checks++;
    if (rq != 1 || dc != 2 || pl != 1 || ab || !ia) begin
      errors++; $display("FAIL word_timing: req=%0d done_at=%0d pulses=%0d addr_bad=%0d idle=%0d want 1/2/1/0/1", rq, dc, pl, ab, ia);
    end
    checks++;
    if (e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL word_data: err=%b data=%h want 0/deadbeef", e, d);
    end
  endtask

  task automatic test_extension;
    int rq, dc, pl, ra; logic e; logic [31:0] d, a, rd, exp; logic [1:0] sz; logic sx; bit ab, ia;
    logic [31:0] da [4] = '{32'h100, 32'h101, 32'h102, 32'h100};
    logic [1:0]  ds [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        dx [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] de [4] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1, 32'h0000_7F82};
    for (int i = 0; i < 4; i++) begin
      run_load(da[i], ds[i], dx[i], 32'h80F1_7F82, 1, 0, rq, dc, pl, e, d, ab, ia);
      model_dout = de[i];
      checks++;
      if (e !== 1'b0 || d !== de[i] || dc != 2 || ab) begin
        errors++; $display("FAIL ext_directed%0d: err=%b data=%h done_at=%0d want 0/%h/2", i, e, d, dc, de[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      sx = 1'($urandom % 2); rd = $urandom; ra = $urandom_range(1, 5);
      run_load(a, sz, sx, rd, ra, 0, rq, dc, pl, e, d, ab, ia);
      exp = ref_ext(rd, a, sz, sx);
      model_dout = exp;
      checks++;
      if (e !== 1'b0 || d !== exp || rq != ra || dc != ra + 1 || pl != 1 || ab || !ia) begin
        errors++; $display("FAIL ext_rand%0d: a=%h sz=%0d sx=%b rd=%h data=%h want %h err=%b req=%0d done_at=%0d pulses=%0d",
                           i, a, sz, sx, rd, d, exp, e, rq, dc, pl);
      end
    end
  endtask

  task automatic test_misalign;
    int rq, dc, pl; logic e; logic [31:0] d, a; logic [1:0] sz; bit ab, ia;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case (i % 3)
        0: begin sz = 2'b10; a[1:0] = 2'($urandom_range(1, 3)); end
        1: begin sz = 2'b01; a[0] = 1'b1; end
        default: sz = 2'b11;
      endcase
      if (i == 0) begin a = 32'h0000_2002; sz = 2'b10; end
      if (i == 1) begin a = 32'h0000_2001; sz = 2'b01; end
      checks++;
      if (ref_legal(a, sz)) begin
        errors++; $display("FAIL misalign_gen%0d: a=%h sz=%0d classified legal", i, a, sz);
      end
      run_load(a, sz, 1'b1, 32'hFFFF_FFFF, 1, 0, rq, dc, pl, e, d, ab, ia);
      checks++;
      if (rq != 0 || dc != 1 || pl != 1 || e !== 1'b1 || d !== model_dout || !ia) begin
        errors++; $display("FAIL misalign%0d: a=%h sz=%0d req=%0d done_at=%0d pulses=%0d err=%b data=%h want 0/1/1/1/%h",
                           i, a, sz, rq, dc, pl, e, d, model_dout);
      end
    end
  endtask

  task automatic test_timeout;
    int rq, dc, pl; logic e; logic [31:0] d, rd; bit ab, ia;
    run_load(32'h0000_4000, 2'b10, 1'b0, 32'hCAFE_F00D, 0, 0, rq, dc, pl, e, d, ab, ia);
    checks++;
    if (rq != 15 || dc != 16 || pl != 1 || e !== 1'b1 || d !== model_dout || ab || !ia) begin
      errors++; $display("FAIL timeout_abort: req=%0d done_at=%0d pulses=%0d err=%b data=%h want 15/16/1/1/%h", rq, dc, pl, e, d, model_dout);
    end
    rd = $urandom;
    run_load(32'h0000_4003, 2'b00, 1'b1, rd, 15, 0, rq, dc, pl, e, d, ab, ia);
    model_dout = ref_ext(rd, 32'h0000_4003, 2'b00, 1'b1);
    checks++;
    if (rq != 15 || dc != 16 || pl != 1 || e !== 1'b0 || d !== model_dout) begin
      errors++; $display("FAIL timeout_edge_ok: req=%0d done_at=%0d err=%b data=%h want 15/16/0/%h", rq, dc, e, d, model_dout);
    end
  endtask

  task automatic test_reset_mid_req;
    checks++;
    if (model_dout === 32'h0 || data_out !== model_dout) begin
      errors++; $display("FAIL pre_reset_data: data_out=%h want nonzero %h", data_out, model_dout);
    end
    addr = 32'h0000_5008; size = 2'b10; sign_ext = 1'b0; start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_req_third: mem_req=%b want 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_req_reset: req=%b data=%h busy=%b done=%b want 0/0/0/0", mem_req, data_out, busy, done);
    end
    rst = 1'b0; model_dout = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start;
    int rq, dc, pl; logic e; logic [31:0] d, rd; bit ab, ia;
    rd = $urandom;
    run_load(32'h0000_6006, 2'b01, 1'b1, rd, 6, 1, rq, dc, pl, e, d, ab, ia);
    model_dout = ref_ext(rd, 32'h0000_6006, 2'b01, 1'b1);
    checks++;
    if (rq != 6 || dc != 7 || pl != 1 || e !== 1'b0 || d !== model_dout || ab || !ia) begin
      errors++; $display("FAIL ignored_start: req=%0d done_at=%0d pulses=%0d err=%b data=%h want 6/7/1/0/%h", rq, dc, pl, e, d, model_dout);
    end
  endtask

  task automatic test_back_to_back;
    addr = 32'h0000_2000; size = 2'b10; sign_ext = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || data_out !== 32'h1357_9BDF) begin
      errors++; $display("FAIL b2b_first: done=%b data=%h want 1/13579bdf", done, data_out);
    end
    addr = 32'h0000_3002; size = 2'b01; sign_ext = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: busy=%b req=%b done=%b want 0/0/0", busy, mem_req, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL b2b_second_req: req=%b addr=%h want 1/00003000", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'hA5C3_0000;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    model_dout = 32'h0000_A5C3;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || data_out !== model_dout) begin
      errors++; $display("FAIL b2b_second: done=%b err=%b data=%h want 1/0/%h", done, err, data_out, model_dout);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0; model_dout = '0;
    rst = 1'b1; start = 1'b0; addr = '0; size = '0; sign_ext = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_word_load();
    test_extension();
    test_misalign();
    test_timeout();
    test_reset_mid_req();
    test_word_load();
    test_ignored_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_read_unit.md
Name: load_read_unit

Overview:
- Multi-cycle load reader for the MIPS32 datapath; the read-side counterpart of the 32-bit enable register that writes datapath state.
- On a start strobe, it issues one word read to data memory over a req/ready handshake and waits for the response.
- It then extracts the byte, halfword or word, zero- or sign-extends it, and latches it into a held 32-bit output (MDR role).
- It reports completion with a done pulse, plus err for misalignment or timeout.

Parameters:
- TIMEOUT, 15: maximum cycles in REQ without mem_ready before aborting with err; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  launch load; sampled only in IDLE
- addr  in  32  byte address of load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  1 = sign-extend byte/half, 0 = zero-extend
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 = misaligned/illegal size or timeout
- data_out  out  32  last successfully loaded value, held
- mem_req  out  1  read request to data memory
- mem_addr  out  32  word-aligned request address, {addr[31:2],2'b00}
- mem_rdata  in  32  memory read word, valid when mem_ready=1
- mem_ready  in  1  memory response strobe

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE; busy=0, done=0, err=0, mem_req=0, mem_addr=0, data_out=0, timeout counter=0.
  - Reset overrides everything, including mid-transaction; mem_req is low the cycle after the reset edge.
- States: IDLE, REQ, DONE.
- IDLE:
  - On start=1, capture addr, size and sign_ext into internal registers.
  - Misaligned or illegal cases: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
  - If misaligned or illegal: next state DONE with err=1; no memory request is issued.
  - Otherwise: next state REQ, counter cleared.
- REQ:
  - mem_req=1; mem_addr is driven from the captured address and stays stable for the whole state.
  - If mem_ready=1: latch the extracted value into data_out at that edge; next state DONE with err=0.
  - Else the counter increments. If the counter reaches TIMEOUT (i.e. TIMEOUT REQ cycles with no ready), next state DONE with err=1; data_out is unchanged.
  - mem_ready arriving in the same cycle as the timeout counts as success.
- DONE:
  - done=1 for exactly one cycle, with err valid; mem_req=0.
  - Next state IDLE unconditionally.
- start in REQ or DONE is ignored; no queuing.
- mem_ready outside REQ is ignored.
- Extraction (little-endian):
  - Byte lane = addr[1:0]: 00 → [7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24].
  - Halfword lane = addr[1]: 0 → [15:0], 1 → [31:16].
  - Word: mem_rdata as is.
  - Extension: sign_ext=1 replicates the MSB of the selected field into the upper bits; sign_ext=0 fills with zeros.
- Latency:
  - start at edge N → mem_req high during cycle N+1.
  - Ready on first REQ cycle → done during cycle N+2.
  - Misaligned → done during cycle N+1.
- data_out changes only on a successful load or on reset.
- Back-to-back operation: start may be asserted in the cycle done is high, but is only accepted once back in IDLE (cycle after done).

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0, busy=0; assert start with rst=1 → no mem_req.
- Word load: addr=0x0000_1004, size=10, mem_ready on first REQ cycle with mem_rdata=0xDEAD_BEEF → mem_addr=0x0000_1004, done at N+2, err=0, data_out=0xDEAD_BEEF.
- Byte/half extension on mem_rdata=0x80F1_7F82:
  - addr low bits 00, byte, sign_ext=1 → 0xFFFF_FF82.
  - Byte lane 01, sign_ext=0 → 0x0000_007F.
  - Half at addr[1]=1, sign_ext=1 → 0xFFFF_80F1.
  - Half at addr[1]=0, sign_ext=0 → 0x0000_7F82.
- Misalignment: word at addr=0x...02, half at addr=0x...01, and size=11 → no mem_req, done at N+1 with err=1, data_out holds previous value.
- Timeout: TIMEOUT=15, mem_ready never asserted → mem_req high exactly 15 cycles, then done with err=1, data_out unchanged. Repeat with ready on the 15th REQ cycle → success, err=0.
- Reset mid-REQ plus ignored start:
  - Assert rst on the 3rd REQ cycle → mem_req=0 and data_out=0 next cycle, state IDLE.
  - Separately, pulse start during REQ → no second request and a single done pulse.
